a2d_sequencer: RTL and testbench



---
 rtl/a2d_sequencer.sv | 250 +++++++++++++++++++++++++
 tb/tb_a2d_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/a2d_sequencer.sv
// ---------------------------------------------------------------------------
// a2d_sequencer
//
// Round-robin conversion controller for the ADC128S 12-bit A2D. Each accepted
// `nxt` request runs one two-frame SPI exchange with the A2D. The exchange
// targets the next channel in the fixed order 0 -> 4 -> 5 -> 0. The A2D
// returns the result of the channel addressed in the *previous* frame. For
// that reason the same command is sent twice, and only the second frame's
// read data is kept.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   nxt        in   one-cycle request for the next conversion (IDLE only)
//   MISO       in   serial data from the A2D
//   SS_n       out  active-low slave select (idles high)
//   SCLK       out  serial clock = clk/32 (idles high)
//   MOSI       out  serial command data (command shift register MSB)
//   lft_ld     out  last channel-0 result
//   rght_ld    out  last channel-4 result
//   batt       out  last channel-5 result
//   busy       out  conversion in progress
//   cnv_cmplt  out  one-cycle pulse when a result register updates
// ---------------------------------------------------------------------------
module a2d_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] batt,
    output logic        busy,
    output logic        cnv_cmplt
);

    // Sequencer states
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] TXN1 = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;
    localparam logic [1:0] TXN2 = 2'd3;

    // Preload for the SCLK divider. From 22 the divider MSB stays high for
    // 10 clocks (the front porch). It then wraps and gives 16 clocks low
    // and 16 clocks high per bit.
    localparam logic [4:0] DIV_LOAD = 5'b10110;

    // Channel sequence helper: 0 -> 4 -> 5 -> 0.
    function automatic logic [2:0] next_ptr(input logic [2:0] p);
        logic [2:0] n;
        case (p)
            3'd0:    n = 3'd4;
            3'd4:    n = 3'd5;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

    // Command word for a channel: channel address in bits [13:11].
    function automatic logic [15:0] cmd_word(input logic [2:0] p);
        return {2'b00, p, 11'h000};
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]  state_r;
    logic [1:0]  state_nxt_s;
    logic [2:0]  ptr_r;
    logic [11:0] lft_r;
    logic [11:0] rght_r;
    logic [11:0] batt_r;
    logic        busy_r;
    logic        cnv_cmplt_r;

    // SPI master state
    logic [4:0]  div_r;
    logic [15:0] shft_r;
    logic        smp_r;
    logic [4:0]  bit_cnt_r;
    logic        ss_n_r;
    logic        done_r;

    // ------------------------------------------------------------------
    // Combinational decodes
    // ------------------------------------------------------------------
    logic        accept_s;
    logic        start_s;
    logic        active_s;
    logic        edge31_s;
    logic        shift_s;
    logic        last_s;
    logic        cmplt_s;
    logic [15:0] shft_nxt_s;

    // Decode SPI events and sequencer handshakes
    always_comb begin
        accept_s   = (state_r == IDLE) && nxt;
        // A frame starts on an accepted request or on the single GAP cycle.
        start_s    = accept_s || (state_r == GAP);
        active_s   = !ss_n_r;
        edge31_s   = active_s && (div_r == 5'd31);
        // The first divider wrap ends the front porch. No bit has been
        // sampled yet, so that wrap only advances the bit counter.
        shift_s    = edge31_s && (bit_cnt_r != 5'd0);
        last_s     = edge31_s && (bit_cnt_r == 5'd16);
        cmplt_s    = (state_r == TXN2) && last_s;
        shft_nxt_s = {shft_r[14:0], smp_r};
    end

    // SPI master: divider, shifter, MISO sample flop, framing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r     <= DIV_LOAD;
            shft_r    <= 16'h0000;
            smp_r     <= 1'b0;
            bit_cnt_r <= 5'd0;
            ss_n_r    <= 1'b1;
            done_r    <= 1'b0;
        end else if (start_s) begin
            div_r     <= DIV_LOAD;
            shft_r    <= cmd_word(ptr_r);
            smp_r     <= smp_r;
            bit_cnt_r <= 5'd0;
            ss_n_r    <= 1'b0;
            done_r    <= 1'b0;
        end else if (active_s) begin
            done_r <= last_s;
            // Sample the cycle before SCLK rises so the A2D data has had
            // the whole low half-period to settle.
            if (div_r == 5'd15) begin
                smp_r <= MISO;
            end else begin
                smp_r <= smp_r;
            end
            if (shift_s) begin
                shft_r <= shft_nxt_s;
            end else begin
                shft_r <= shft_r;
            end
            if (last_s) begin
                // Keep SCLK high after the last bit, ready for the next frame.
                div_r     <= DIV_LOAD;
                bit_cnt_r <= 5'd0;
                ss_n_r    <= 1'b1;
            end else if (edge31_s) begin
                div_r     <= div_r + 5'd1;
                bit_cnt_r <= bit_cnt_r + 5'd1;
                ss_n_r    <= 1'b0;
            end else begin
                div_r     <= div_r + 5'd1;
                bit_cnt_r <= bit_cnt_r;
                ss_n_r    <= 1'b0;
            end
        end else begin
            div_r     <= div_r;
            shft_r    <= shft_r;
            smp_r     <= smp_r;
            bit_cnt_r <= bit_cnt_r;
            ss_n_r    <= 1'b1;
            done_r    <= 1'b0;
        end
    end

    // Sequencer next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (nxt) begin
                    state_nxt_s = TXN1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            TXN1: begin
                if (done_r) begin
                    state_nxt_s = GAP;
                end else begin
                    state_nxt_s = TXN1;
                end
            end
            // GAP is one cycle. SS_n is also high during the done cycle,
            // which gives two clocks high between the frames.
            GAP: begin
                state_nxt_s = TXN2;
            end
            TXN2: begin
                if (done_r) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = TXN2;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Result capture, channel pointer, busy and completion pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r       <= 3'd0;
            lft_r       <= 12'h000;
            rght_r      <= 12'h000;
            batt_r      <= 12'h000;
            busy_r      <= 1'b0;
            cnv_cmplt_r <= 1'b0;
        end else if (cmplt_s) begin
            // Capture the final shift value directly, so the result lands
            // on the same edge as the last bit.
            case (ptr_r)
                3'd0:    lft_r  <= shft_nxt_s[11:0];
                3'd4:    rght_r <= shft_nxt_s[11:0];
                3'd5:    batt_r <= shft_nxt_s[11:0];
                default: lft_r  <= lft_r;
            endcase
            ptr_r       <= next_ptr(ptr_r);
            busy_r      <= 1'b0;
            cnv_cmplt_r <= 1'b1;
        end else begin
            ptr_r       <= ptr_r;
            busy_r      <= busy_r | accept_s;
            cnv_cmplt_r <= 1'b0;
        end
    end

    assign SS_n      = ss_n_r;
    assign SCLK      = div_r[4];
    assign MOSI      = shft_r[15];
    assign lft_ld    = lft_r;
    assign rght_ld   = rght_r;
    assign batt      = batt_r;
    assign busy      = busy_r;
    assign cnv_cmplt = cnv_cmplt_r;

endmodule

// File: tb/tb_a2d_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for a2d_sequencer: ADC128S behavioural model, a timeline-based
// reference model of busy/cnv_cmplt/SS_n/results, a bus monitor and directed
// conversions.
// ---------------------------------------------------------------------------
module tb_a2d_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        nxt = 1'b0;
    logic        MISO;
    logic        SS_n, SCLK, MOSI, busy, cnv_cmplt;
    logic [11:0] lft_ld, rght_ld, batt;

    int checks = 0;
    int errors = 0;

    a2d_sequencer dut (
        .clk(clk), .rst_n(rst_n), .nxt(nxt), .MISO(MISO),
        .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
        .lft_ld(lft_ld), .rght_ld(rght_ld), .batt(batt),
        .busy(busy), .cnv_cmplt(cnv_cmplt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- ADC128S model ----------------
    // The model returns the conversion of the channel that was addressed in
    // the previous frame. It presents a bit before the first rising edge.
    // After that it presents the next bit on each SCLK fall.
    logic [11:0] adc_data [0:7];
    logic [15:0] adc_tx = 16'h0000;
    logic [15:0] adc_rx = 16'h0000;
    logic        adc_first = 1'b0;
    logic [2:0]  adc_prev_ch = 3'd0;

    assign MISO = adc_tx[15];

    always @(negedge SS_n) begin
        adc_tx    = {4'h0, adc_data[adc_prev_ch]};
        adc_first = 1'b1;
        adc_rx    = 16'h0000;
    end
    always @(negedge SCLK) begin
        if (!SS_n) begin
            if (adc_first) adc_first = 1'b0;
            else           adc_tx = {adc_tx[14:0], 1'b0};
        end
    end
    always @(posedge SCLK) begin
        if (!SS_n) adc_rx = {adc_rx[14:0], MOSI};
    end
    always @(posedge SS_n) adc_prev_ch = adc_rx[13:11];

    // ---------------- Reference model + bus monitor ----------------
    // Model: a conversion accepted in cycle A drives the outputs as follows.
    // SS_n is low in cycles A+1..A+522 and again in A+525..A+1046. busy is
    // high in A+1..A+1046. cnv_cmplt fires, and the results update, in
    // A+1047. The block is idle again from A+1048.
    int          order [3] = '{0, 4, 5};
    int          n = 0;
    int          acc = -1;
    int          acc_ch = 0;
    int          ptr_idx = 0;
    logic [11:0] e_lft = 12'h000, e_rght = 12'h000, e_batt = 12'h000;
    logic [15:0] cmd_q [$];
    logic [15:0] frame_log [$];
    logic        prev_ss = 1'b1, prev_sclk = 1'b1, prev_mosi = 1'b0;
    logic        chk_next = 1'b0, mosi_ref = 1'b0, frame_abort = 1'b1;
    int          low_cnt = 0, rises = 0;
    logic [15:0] rxw = 16'h0000;

    initial begin : compare
        int  k;
        logic ss_e, busy_e, cm_e;
        logic [15:0] cmd;
        forever begin
            @(negedge clk);
            n++;
            if (!rst_n) begin
                acc = -1; ptr_idx = 0;
                e_lft = 12'h000; e_rght = 12'h000; e_batt = 12'h000;
                cmd_q.delete();
                prev_ss = 1'b1; prev_sclk = 1'b1; chk_next = 1'b0; frame_abort = 1'b1;
            end else begin
                k = (acc >= 0) ? (n - acc) : -1;
                if (k == 1047) begin
                    case (acc_ch)
                        0:       e_lft  = adc_data[0];
                        4:       e_rght = adc_data[4];
                        default: e_batt = adc_data[5];
                    endcase
                    ptr_idx = (ptr_idx + 1) % 3;
                end
                ss_e   = !((k >= 1 && k <= 522) || (k >= 525 && k <= 1046));
                busy_e = (k >= 1 && k <= 1046);
                cm_e   = (k == 1047);
                chk("ss_n", SS_n, ss_e);
                chk("busy", busy, busy_e);
                chk("cnv_cmplt", cnv_cmplt, cm_e);
                if (ss_e) chk("sclk_idle", SCLK, 1'b1);
                chk("lft_ld", lft_ld, e_lft);
                chk("rght_ld", rght_ld, e_rght);
                chk("batt", batt, e_batt);

                // Bus monitor
                if (chk_next) begin
                    chk("mosi_after_rise", MOSI, mosi_ref);
                    chk_next = 1'b0;
                end
                if (prev_ss && !SS_n) begin
                    low_cnt = 0; rises = 0; rxw = 16'h0000; frame_abort = 1'b0;
                end
                if (!SS_n) begin
                    low_cnt++;
                    if (!prev_sclk && SCLK) begin
                        rises++;
                        rxw = {rxw[14:0], MOSI};
                        chk("mosi_before_rise", MOSI, prev_mosi);
                        chk_next = 1'b1;
                        mosi_ref = MOSI;
                    end
                end
                if (!prev_ss && SS_n && !frame_abort) begin
                    chk("frame_len", low_cnt, 522);
                    chk("frame_rises", rises, 16);
                    if (cmd_q.size() == 0) begin
                        chk("frame_expected", 1'b0, 1'b1);
                    end else begin
                        cmd = cmd_q.pop_front();
                        chk("frame_cmd", rxw, cmd);
                    end
                    frame_log.push_back(rxw);
                end

                // Acceptance: only when the block is idle.
                if (nxt && (acc < 0 || k >= 1048)) begin
                    acc    = n;
                    acc_ch = order[ptr_idx];
                    cmd    = 16'h0000;
                    cmd[13:11] = acc_ch[2:0];
                    cmd_q.push_back(cmd);
                    cmd_q.push_back(cmd);
                end
                prev_ss   = SS_n;
                prev_sclk = SCLK;
                prev_mosi = MOSI;
            end
        end
    end

    // ---------------- Stimulus ----------------
    task automatic conv(output int lat);
        @(posedge clk); #1 nxt = 1'b1;
        @(posedge clk); #1 nxt = 1'b0;
        lat = -1;
        for (int i = 1; i < 2000; i++) begin
            if (cnv_cmplt) begin
                lat = i;
                break;
            end
            @(posedge clk); #1;
        end
        chk("conv_done_in_time", (lat > 0), 1'b1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int lat;
        int f0;
        int pulses;
        for (int i = 0; i < 8; i++) adc_data[i] = 12'h000;
        adc_data[0] = 12'hC00;
        adc_data[4] = 12'h5A5;
        adc_data[5] = 12'hDEF;

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ss_n", SS_n, 1'b1);
        chk("rst_sclk", SCLK, 1'b1);
        chk("rst_mosi", MOSI, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cnv", cnv_cmplt, 1'b0);
        chk("rst_results", {lft_ld, rght_ld, batt}, 36'h0);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Conversion 1: channel 0
        conv(lat);
        chk("lat_ch0", lat, 1047);
        chk("lft_C00", lft_ld, 12'hC00);
        chk("cmd0_f0", frame_log[0], 16'h0000);
        chk("cmd0_f1", frame_log[1], 16'h0000);

        // Conversions 2 and 3: channels 4 and 5
        conv(lat);
        chk("rght_5A5", rght_ld, 12'h5A5);
        chk("cmd4", frame_log[2], 16'h2000);
        conv(lat);
        chk("batt_DEF", batt, 12'hDEF);
        chk("cmd5", frame_log[4], 16'h2800);

        // Conversion 4 wraps to channel 0 and overwrites it
        adc_data[0] = 12'h123;
        conv(lat);
        chk("lft_123", lft_ld, 12'h123);
        chk("cmd_wrap", frame_log[6], 16'h0000);
        chk("rght_hold", rght_ld, 12'h5A5);

        // nxt pulses during TXN1, GAP and TXN2, and together with cnv_cmplt
        f0 = frame_log.size();
        pulses = 0;
        @(posedge clk); #1 nxt = 1'b1;
        for (int i = 1; i <= 1060; i++) begin
            @(posedge clk); #1;
            nxt = (i == 100 || i == 523 || i == 524 || i == 800 || i == 1047);
            if (cnv_cmplt) pulses++;
        end
        nxt = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("no_extra_frames", frame_log.size(), f0 + 2);
        chk("one_cmplt", pulses, 1);
        chk("busy_idle", busy, 1'b0);

        // Reset at the 300th clock of TXN2 (channel 5 conversion)
        @(posedge clk); #1 nxt = 1'b1;
        @(posedge clk); #1 nxt = 1'b0;
        repeat (823) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ss_n", SS_n, 1'b1);
        chk("arst_sclk", SCLK, 1'b1);
        chk("arst_mosi", MOSI, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_results", {lft_ld, rght_ld, batt}, 36'h0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        conv(lat);
        chk("lat_after_rst", lat, 1047);
        chk("lft_after_rst", lft_ld, 12'h123);
        chk("cmd_after_rst", frame_log[frame_log.size() - 1], 16'h0000);
        conv(lat);
        chk("rght_after_rst", rght_ld, 12'h5A5);

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
